serve_rally_sched: RTL and testbench
====================================

// Module: serve_rally_sched
// PURPOSE
//  Sequencing controller for the pingpong game FSM. Generates frame and match-second timing,
//  produces the play-time counter time_cnt, gates the serve buttons seen by the next-state logic,
//  and schedules ball speed from paddle-hit events. Sits between the board buttons/ball logic and the FSM.
// PARAMETERS
//  FRAME_DIV        833333    clk cycles per frame_tick (60 Hz at 50 MHz)
//  TICKS_PER_SEC    50000000  clk cycles per match second
//  MATCH_SECONDS    60        time_cnt saturation value; time_up asserts here
//  SERVE_LOCK_FRAMES 30       frames the serve buttons stay blocked after entering a serve state
//  SPEED_STEP_HITS  4         paddle hits per ball_speed increment
//  MAX_SPEED        7         ball_speed ceiling (<=7)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  game_state  in   2  0=p1 serve, 1=p2 serve, 2=playing, 3=end
//  p1l,p1r     in   1  raw p1 buttons, active-low, asynchronous
//  p2l,p2r     in   1  raw p2 buttons, active-low, asynchronous
//  hit         in   1  one-clk pulse from ball logic on any paddle hit
//  p1l_g,p1r_g out  1  gated p1 buttons to FSM, active-low
//  p2l_g,p2r_g out  1  gated p2 buttons to FSM, active-low
//  frame_tick  out  1  one-clk pulse every FRAME_DIV cycles
//  time_cnt    out  6  elapsed play seconds, saturating at MATCH_SECONDS
//  time_up     out  1  time_cnt >= MATCH_SECONDS
//  serve_ok    out  1  serving player may launch the ball
//  ball_speed  out  3  pixels per frame for ball mover; 0 = ball frozen
// BEHAVIOUR
//  Reset (async, any time, mid-rally included): all counters 0, time_cnt=0, time_up=0, frame_tick=0,
//   serve_ok=0, ball_speed=0, gated buttons=1, sync FFs=1, state=LOCK, lock counter=SERVE_LOCK_FRAMES.
//  Buttons: 2-FF synchronizers, reset to 1. game_state is registered as gs_q; entry = gs != gs_q.
//  Frame prescaler: free-running 0..FRAME_DIV-1. frame_tick=1 for the cycle after the count wraps.
//   Runs in every state.
//  Second counter: advances only while game_state==2 and holds otherwise, so time is cumulative
//   play time. On wrap, time_cnt+1, saturating at MATCH_SECONDS.
//   time_up is registered and is high from the cycle after time_cnt reaches MATCH_SECONDS.
//   time_cnt clears only on reset.
//  Scheduler FSM (registered):
//   LOCK  : entered on any entry into state 0 or 1. Lock counter loads SERVE_LOCK_FRAMES and
//           decrements on each frame_tick. At 0 -> RELEASE.
//   RELEASE: waits until both synced buttons of the server (p1 for 0, p2 for 1) are 1 -> READY.
//   READY : serve_ok=1. The server's gated buttons = synced values; the non-server's gated buttons = 1.
//   RALLY : entered on entry into state 2. ball_speed=1 and hit_cnt=0 on entry.
//           On each hit, hit_cnt+1. When the hit makes hit_cnt==SPEED_STEP_HITS:
//           hit_cnt=0 and ball_speed+1, saturating at MAX_SPEED.
//   FROZEN: entered on entry into state 3. Terminal until reset.
//  In all states except READY: serve_ok=0 and all gated buttons=1.
//  Outside RALLY, ball_speed=0 and hit is ignored.
//  A game_state entry overrides the current FSM state in the same cycle, including mid-LOCK.
//  hit on the same cycle as RALLY entry is ignored.
//  Latency: raw button edge -> gated output = 3 clk (2 sync + 1 out reg).
//   READY->serve_ok = 1 clk after release is detected.
// TESTING (bench params: FRAME_DIV=4, TICKS_PER_SEC=10, MATCH_SECONDS=3, SERVE_LOCK_FRAMES=2, SPEED_STEP_HITS=2, MAX_SPEED=3)
//  Reset, gs=0, p1l held 0 -> gated buttons stay 1 through LOCK and RELEASE.
//   Release p1l -> serve_ok=1 within 2 clk after sync. Press p1l -> p1l_g=0 3 clk later; p2l_g stays 1.
//  Reset, gs=0 -> frame_tick pulses every 4 clk; serve_ok rises only after 2 frame_ticks.
//  gs=2, 5 hit pulses -> ball_speed 1,1,2,2,3,3 (saturates at 3).
//   gs->1 -> ball_speed=0 next clk.
//  gs=2 for 35 clk -> time_cnt=3, time_up=1, and time_cnt holds at 3.
//   gs=0 for 20 clk, then gs=2 -> counting resumes from the held sub-second value.
//  gs=3 mid-LOCK -> FROZEN: serve_ok=0, ball_speed=0, gated buttons=1, frame_tick still running.
//  Assert reset mid-RALLY with ball_speed=2 -> all outputs at reset values the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/serve_rally_sched.sv
// serve_rally_sched: timing and sequencing helper for the pingpong game FSM.
// Produces the frame tick and the cumulative play-time counter, gates the
// serve buttons that the FSM sees, and raises ball speed as paddle hits add up.
module serve_rally_sched #(
   parameter int FRAME_DIV         = 833333,
   parameter int TICKS_PER_SEC     = 50000000,
   parameter int MATCH_SECONDS     = 60,
   parameter int SERVE_LOCK_FRAMES = 30,
   parameter int SPEED_STEP_HITS   = 4,
   parameter int MAX_SPEED         = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] game_state,
   input  logic       p1l,
   input  logic       p1r,
   input  logic       p2l,
   input  logic       p2r,
   input  logic       hit,
   output logic       p1l_g,
   output logic       p1r_g,
   output logic       p2l_g,
   output logic       p2r_g,
   output logic       frame_tick,
   output logic [5:0] time_cnt,
   output logic       time_up,
   output logic       serve_ok,
   output logic [2:0] ball_speed
);

   localparam int DIV_W  = (FRAME_DIV > 1)         ? $clog2(FRAME_DIV)           : 1;
   localparam int SEC_W  = (TICKS_PER_SEC > 1)     ? $clog2(TICKS_PER_SEC)       : 1;
   localparam int LOCK_W = (SERVE_LOCK_FRAMES > 0) ? $clog2(SERVE_LOCK_FRAMES+1) : 1;
   localparam int HIT_W  = (SPEED_STEP_HITS > 0)   ? $clog2(SPEED_STEP_HITS+1)   : 1;

   typedef enum logic [2:0] {
      ST_LOCK,
      ST_RELEASE,
      ST_READY,
      ST_RALLY,
      ST_FROZEN
   } state_t;

   state_t            state;
   logic [3:0]        sync1, sync2;   // {p2r, p2l, p1r, p1l}
   logic [1:0]        gs_q;
   logic              entry;
   logic [DIV_W-1:0]  div_cnt;
   logic [SEC_W-1:0]  sec_cnt;
   logic [LOCK_W-1:0] lock_cnt;
   logic [HIT_W-1:0]  hit_cnt;
   logic              srv_l, srv_r;

   assign entry = (game_state != gs_q);

   // Server's synchronized buttons: p1 serves in state 0, p2 in state 1.
   assign srv_l = gs_q[0] ? sync2[2] : sync2[0];
   assign srv_r = gs_q[0] ? sync2[3] : sync2[1];

   // Two-flop synchronizers for the asynchronous buttons, plus game_state history.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: synchronizers reset to 1 (released) so no phantom press is seen after reset.
         sync1 <= 4'hF;
         sync2 <= 4'hF;
         gs_q  <= 2'd0;
      end else begin
         sync1 <= {p2r, p2l, p1r, p1l};
         sync2 <= sync1;
         gs_q  <= game_state;
      end
   end

   // Free-running frame prescaler; tick is registered on the wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= (div_cnt == DIV_W'(FRAME_DIV - 1));
         if (div_cnt == DIV_W'(FRAME_DIV - 1))
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;
      end
   end

   // Cumulative play-time: sub-second count only advances while playing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_cnt  <= '0;
         time_cnt <= '0;
         time_up  <= 1'b0;
      end else begin
         time_up <= (time_cnt >= 6'(MATCH_SECONDS));
         if (game_state == 2'd2) begin
            if (sec_cnt == SEC_W'(TICKS_PER_SEC - 1)) begin
               sec_cnt <= '0;
               if (time_cnt < 6'(MATCH_SECONDS))
                  time_cnt <= time_cnt + 1'b1;
            end else begin
               sec_cnt <= sec_cnt + 1'b1;
            end
         end
      end
   end

   // Scheduler FSM with registered serve/gate/speed outputs; entries override current state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_LOCK;
         lock_cnt   <= LOCK_W'(SERVE_LOCK_FRAMES);
         hit_cnt    <= '0;
         ball_speed <= 3'd0;
         serve_ok   <= 1'b0;
         p1l_g      <= 1'b1;
         p1r_g      <= 1'b1;
         p2l_g      <= 1'b1;
         p2r_g      <= 1'b1;
      end else begin
         serve_ok <= 1'b0;
         p1l_g    <= 1'b1;
         p1r_g    <= 1'b1;
         p2l_g    <= 1'b1;
         p2r_g    <= 1'b1;
         if (entry) begin
            case (game_state)
               2'd0, 2'd1: begin
                  state      <= ST_LOCK;
                  lock_cnt   <= LOCK_W'(SERVE_LOCK_FRAMES);
                  ball_speed <= 3'd0;
               end
               2'd2: begin
                  state      <= ST_RALLY;
                  ball_speed <= 3'd1;
                  hit_cnt    <= '0;
               end
               default: begin
                  state      <= ST_FROZEN;
                  ball_speed <= 3'd0;
               end
            endcase
         end else begin
            case (state)
               ST_LOCK: begin
                  if (lock_cnt == '0)
                     state <= ST_RELEASE;
                  else if (frame_tick)
                     lock_cnt <= lock_cnt - 1'b1;
               end
               ST_RELEASE: begin
                  if (srv_l && srv_r) begin
                     state    <= ST_READY;
                     serve_ok <= 1'b1;
                  end
               end
               ST_READY: begin
                  serve_ok <= 1'b1;
                  if (gs_q[0]) begin
                     p2l_g <= sync2[2];
                     p2r_g <= sync2[3];
                  end else begin
                     p1l_g <= sync2[0];
                     p1r_g <= sync2[1];
                  end
               end
               ST_RALLY: begin
                  if (hit) begin
                     if (hit_cnt == HIT_W'(SPEED_STEP_HITS - 1)) begin
                        hit_cnt <= '0;
                        if (ball_speed < 3'(MAX_SPEED))
                           ball_speed <= ball_speed + 1'b1;
                     end else begin
                        hit_cnt <= hit_cnt + 1'b1;
                     end
                  end
               end
               default: ;  // ST_FROZEN holds until reset
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serve_rally_sched.sv
// Directed self-checking bench for serve_rally_sched with small timing parameters.
module tb_serve_rally_sched;

   localparam int FRAME_DIV         = 4;
   localparam int TICKS_PER_SEC     = 10;
   localparam int MATCH_SECONDS     = 3;
   localparam int SERVE_LOCK_FRAMES = 2;
   localparam int SPEED_STEP_HITS   = 2;
   localparam int MAX_SPEED         = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] game_state;
   logic       p1l, p1r, p2l, p2r, hit;
   logic       p1l_g, p1r_g, p2l_g, p2r_g;
   logic       frame_tick, time_up, serve_ok;
   logic [5:0] time_cnt;
   logic [2:0] ball_speed;

   int n_tests = 0;
   int n_fail  = 0;

   serve_rally_sched #(
      .FRAME_DIV(FRAME_DIV), .TICKS_PER_SEC(TICKS_PER_SEC), .MATCH_SECONDS(MATCH_SECONDS),
      .SERVE_LOCK_FRAMES(SERVE_LOCK_FRAMES), .SPEED_STEP_HITS(SPEED_STEP_HITS), .MAX_SPEED(MAX_SPEED)
   ) dut (
      .clk(clk), .reset(reset), .game_state(game_state),
      .p1l(p1l), .p1r(p1r), .p2l(p2l), .p2r(p2r), .hit(hit),
      .p1l_g(p1l_g), .p1r_g(p1r_g), .p2l_g(p2l_g), .p2r_g(p2r_g),
      .frame_tick(frame_tick), .time_cnt(time_cnt), .time_up(time_up),
      .serve_ok(serve_ok), .ball_speed(ball_speed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] gs);
      reset = 1'b0;
      game_state = gs;
      {p1l, p1r, p2l, p2r} = 4'hF;
      hit = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_gates"}, {p1l_g, p1r_g, p2l_g, p2r_g}, 4'hF);
      check({tag, "_serve_ok"}, serve_ok, 1'b0);
      check({tag, "_speed"}, ball_speed, 3'd0);
      check({tag, "_time_cnt"}, time_cnt, 6'd0);
      check({tag, "_time_up"}, time_up, 1'b0);
      check({tag, "_frame_tick"}, frame_tick, 1'b0);
   endtask

   task automatic pulse_hit();
      hit = 1'b1;
      step(1);
      hit = 1'b0;
   endtask

   initial begin
      int ticks;
      bit rose;
      bit bad;

      // ---- Serve gating with p1l held during lock ----
      do_reset(2'd0);
      p1l = 1'b0;
      check_reset_vals("rst1");
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if ({p1l_g, p1r_g, p2l_g, p2r_g} !== 4'hF || serve_ok !== 1'b0) bad = 1'b1;
      end
      check("held_gates_closed", bad, 1'b0);
      p1l = 1'b1;
      step(2);
      check("serve_ok_during_sync", serve_ok, 1'b0);
      step(1);
      check("serve_ok_after_sync", serve_ok, 1'b1);
      p1l = 1'b0;
      step(2);
      check("p1l_g_at_2clk", p1l_g, 1'b1);
      step(1);
      check("p1l_g_at_3clk", p1l_g, 1'b0);
      check("p2l_g_nonserver", p2l_g, 1'b1);
      check("p1r_g_idle", p1r_g, 1'b1);
      p2l = 1'b0;
      step(5);
      check("p2l_g_blocked", p2l_g, 1'b1);
      check("serve_ok_holds", serve_ok, 1'b1);

      // ---- Frame tick cadence and lock duration ----
      do_reset(2'd0);
      ticks = 0;
      rose  = 1'b0;
      for (int e = 1; e <= 40 && !rose; e++) begin
         step(1);
         if (e <= 12) check($sformatf("frame_tick_e%0d", e), frame_tick, (e % 4 == 0));
         if (serve_ok === 1'b1) begin
            rose = 1'b1;
            check("lock_ticks_ge2", (ticks >= 2), 1'b1);
         end
         if (frame_tick === 1'b1) ticks++;
      end
      check("serve_ok_rose", rose, 1'b1);

      // ---- Rally speed scheduling ----
      do_reset(2'd2);
      check("speed_in_reset", ball_speed, 3'd0);
      step(1);
      check("speed_entry", ball_speed, 3'd1);
      pulse_hit(); check("speed_hit1", ball_speed, 3'd1);
      pulse_hit(); check("speed_hit2", ball_speed, 3'd2);
      pulse_hit(); check("speed_hit3", ball_speed, 3'd2);
      pulse_hit(); check("speed_hit4", ball_speed, 3'd3);
      pulse_hit(); check("speed_hit5", ball_speed, 3'd3);
      pulse_hit(); check("speed_hit6_sat", ball_speed, 3'd3);
      game_state = 2'd1;
      step(1);
      check("speed_leave_rally", ball_speed, 3'd0);

      // ---- Cumulative play time and saturation ----
      do_reset(2'd2);
      step(9);  check("time_e9", time_cnt, 6'd0);
      step(1);  check("time_e10", time_cnt, 6'd1);
      step(5);
      game_state = 2'd0;
      step(20); check("time_hold_serve", time_cnt, 6'd1);
      game_state = 2'd2;
      step(4);  check("time_resume_4", time_cnt, 6'd1);
      step(1);  check("time_resume_5", time_cnt, 6'd2);
      step(10); check("time_reach_max", time_cnt, 6'd3);
      check("time_up_lag", time_up, 1'b0);
      step(1);  check("time_up_set", time_up, 1'b1);
      step(20); check("time_saturated", time_cnt, 6'd3);
      check("time_up_holds", time_up, 1'b1);

      // ---- Frozen entered mid-lock ----
      do_reset(2'd0);
      step(3);
      game_state = 2'd3;
      ticks = 0;
      bad   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         hit = (i % 3 == 0);
         step(1);
         if (frame_tick === 1'b1) ticks++;
         if (i > 0 && (serve_ok !== 1'b0 || ball_speed !== 3'd0 ||
                       {p1l_g, p1r_g, p2l_g, p2r_g} !== 4'hF)) bad = 1'b1;
      end
      hit = 1'b0;
      check("frozen_outputs_idle", bad, 1'b0);
      check("frozen_frame_ticks", ticks, 5);

      // ---- Asynchronous reset mid-rally ----
      do_reset(2'd2);
      step(1);
      pulse_hit();
      pulse_hit();
      check("pre_reset_speed", ball_speed, 3'd2);
      step(9);
      check("pre_reset_time", time_cnt, 6'd1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("async_rst");
      step(1);
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
